// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scanner.
package seven_seg_pkg;

  typedef enum logic {BLANK = 1'b0, ON = 1'b1} scan_state_t;

  localparam int NIBBLE_W = 4;
  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Index/counter width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot counter and BLANK/ON scan FSM; advances digit_idx after each ON phase.
module seven_seg_scan_timer
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = idx_width(NUM_DIGITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  output scan_state_t       phase,
  output logic              slot_done,
  output logic [IDX_W-1:0]  digit_idx,
  output logic              frame_start
);

  localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = idx_width(MAX_CYC);

  logic [CNT_W-1:0] cnt;

  assign slot_done   = (phase == BLANK) ? (cnt == CNT_W'(BLANK_CYCLES - 1))
                                        : (cnt == CNT_W'(ON_CYCLES - 1));
  // First cycle of digit 0's blank phase; the top registers this as its pulse.
  assign frame_start = (phase == BLANK) && (digit_idx == '0) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= BLANK;
      cnt       <= '0;
      digit_idx <= '0;
    end else if (slot_done) begin
      cnt <= '0;
      if (phase == BLANK) begin
        phase <= ON;
      end else begin
        phase     <= BLANK;
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed display scanner with double-buffered load.
// Optional leading-zero blanking: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = idx_width(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output nibble_t                 digit_code,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_start
);

  scan_state_t             t_phase;
  logic                    slot_done_unused;
  logic [IDX_W-1:0]        t_idx;
  logic                    t_frame;

  seven_seg_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .ON_CYCLES    (ON_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .IDX_W        (IDX_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .phase       (t_phase),
    .slot_done   (slot_done_unused),
    .digit_idx   (t_idx),
    .frame_start (t_frame)
  );

  logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] active, pending, active_nxt;
  logic                                pending_full;
  logic                                accept, transfer;
  logic [NUM_DIGITS-1:0]               lz_blank, lit;

  assign load_ready = ~pending_full;
  assign accept     = load_valid && !pending_full;
  assign transfer   = frame_start && pending_full;
  // Output mux looks at the post-transfer value so digit 0 never shows a stale nibble.
  assign active_nxt = transfer ? pending : active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else begin
      active <= active_nxt;
      if (transfer) begin
        pending_full <= 1'b0;
      end else if (accept) begin
        pending      <= value_in;
        pending_full <= 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic zero_above;
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above  = zero_above && (active_nxt[i] == 4'h0);
      lz_blank[i] = zero_above;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign lit = digit_en & ~lz_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_n     <= '1;
      digit_code  <= '0;
      digit_idx   <= '0;
      frame_start <= 1'b0;
    end else begin
      digit_idx   <= t_idx;
      frame_start <= t_frame;
      digit_code  <= active_nxt[t_idx];
      anode_n     <= '1;
      if (t_phase == ON) anode_n[t_idx] <= ~lit[t_idx];
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized self-checking bench; expectations come from a time-based display model.
module tb_seven_segment_scanner;

  localparam int N = 4, O = 4, B = 2;
  localparam int S = B + O;
  localparam int F = N * S;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] value_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  digit_code;
  logic [3:0]  anode_n;
  logic [1:0]  digit_idx;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // Model: k = clock edges since reset release; active/pending buffers.
  int          k = 0;
  bit          m_full = 1'b0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_act  = '0;

  seven_segment_scanner #(
    .NUM_DIGITS(N), .ON_CYCLES(O), .BLANK_CYCLES(B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .value_in    (value_in),
    .digit_en    (digit_en),
    .digit_code  (digit_code),
    .anode_n     (anode_n),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_anode(input int kk, input logic [3:0] en,
                                           input logic [15:0] act);
    int  p, d;
    bit  on;
    p = (kk - 1) % F;
    d = p / S;
    if ((p % S) < B) return 4'hF;
    on = en[d];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (d > 0 && (act >> (4 * d)) == 16'h0) on = 1'b0;
`endif
    return on ? ~(4'b0001 << d) : 4'hF;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_anode"}, 32'(anode_n), 32'hF);
    chk({tag, "_idx"},   32'(digit_idx), 32'h0);
    chk({tag, "_code"},  32'(digit_code), 32'h0);
    chk({tag, "_fs"},    32'(frame_start), 32'h0);
    chk({tag, "_ready"}, 32'(load_ready), 32'h1);
  endtask

  // One clock: drive inputs now (off-edge), take the edge, update model, check.
  task automatic step(input logic lv, input logic [15:0] v, input logic [3:0] en);
    int  p, d;
    bit  fs_prev;
    load_valid = lv;
    value_in   = v;
    digit_en   = en;
    @(posedge clk);
    fs_prev = (k >= 1) && (((k - 1) % F) == 0);
    if (fs_prev && m_full) begin
      m_act  = m_pend;
      m_full = 1'b0;
    end else if (lv && !m_full) begin
      m_pend = v;
      m_full = 1'b1;
    end
    k++;
    #1;
    p = (k - 1) % F;
    d = p / S;
    chk("ready", 32'(load_ready), 32'(!m_full));
    chk("fs",    32'(frame_start), 32'(p == 0));
    chk("idx",   32'(digit_idx), 32'(d));
    chk("code",  32'(digit_code), 32'((m_act >> (4 * d)) & 16'hF));
    chk("anode", 32'(anode_n), 32'(exp_anode(k, en, m_act)));
  endtask

  task automatic model_reset();
    k = 0; m_full = 1'b0; m_pend = '0; m_act = '0;
  endtask

  task automatic run(input int n, input logic [3:0] en);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, en);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] en);
    int guard = 0;
    while (!m_full && guard < 200) begin
      step(1'b1, v, en);
      guard++;
    end
    if (!m_full) chk("load_timeout", 32'(m_full), 32'h1);
  endtask

  initial begin
    #23;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Directed: 1234 after reset, then ABCD mid-frame with a 5555 attempt behind it.
    run(3, 4'hF);
    load(16'h1234, 4'hF);
    run(2 * F, 4'hF);
    run(7, 4'hF);
    load(16'hABCD, 4'hF);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h5555, 4'hF);
    run(2 * F, 4'hF);

    // Partial digit enable mask.
    run(2 * F, 4'b1010);

    // Leading-zero candidates.
    load(16'h0070, 4'hF);
    run(2 * F, 4'hF);
    load(16'h0000, 4'hF);
    run(2 * F, 4'hF);

    // Async reset during ON of digit 2.
    load(16'h9876, 4'hF);
    begin
      int guard = 0;
      while (!(k >= 1 && (((k - 1) % F) / S) == 2 && (((k - 1) % F) % S) > B)
             && guard < 4 * F) begin
        step(1'b0, '0, 4'hF);
        guard++;
      end
      if (guard >= 4 * F) chk("seek_digit2_timeout", 32'(guard), 32'(4 * F - 1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(F + 3, 4'hF);

    // Randomized traffic.
    begin
      logic [3:0] en = 4'hF;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 59) == 0) en = 4'($urandom);
        step($urandom_range(0, 7) == 0, 16'($urandom), en);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
